// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared display-timing constants for the 1024x768 @ 60 Hz world display.
// The scaler and colorizer import COORD_W so that every block agrees on the
// pixel coordinate width.
//   COORD_W            : width of pixel_row / pixel_column (12 bits)
//   COORD_MAX          : largest value a coordinate counter can hold
//   DEF_H_* / DEF_V_*  : default 1024x768 @ 60 Hz porch/sync/visible sizes
//   DEF_H_TOT/V_TOT    : derived line and frame totals (1344 / 806)
//   in_window()        : inclusive range test used by the sync decoders
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int COORD_W   = 12;
    localparam int COORD_MAX = (1 << COORD_W) - 1;

    localparam int DEF_H_VIS  = 1024;
    localparam int DEF_H_FP   = 24;
    localparam int DEF_H_SYNC = 136;
    localparam int DEF_H_BP   = 160;

    localparam int DEF_V_VIS  = 768;
    localparam int DEF_V_FP   = 3;
    localparam int DEF_V_SYNC = 6;
    localparam int DEF_V_BP   = 29;

    localparam int DEF_H_TOT = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOT = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Inclusive window test: lo <= v <= hi
    function automatic logic in_window(
        input logic [COORD_W-1:0] v,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// ---------------------------------------------------------------------------
// wrap_counter
// Free-running up-counter that returns to zero after LAST.
//   clock   : counting clock (rising edge)
//   reset   : asynchronous active-high clear
//   en_i    : advance the count this cycle
//   count_o : current count (registered)
//   wrap_o  : high in the cycle where an enabled count will roll to zero;
//             used to chain a slower counter
// ---------------------------------------------------------------------------
module wrap_counter #(
    parameter int              WIDTH = 12,
    parameter logic [WIDTH-1:0] LAST  = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign wrap_o = en_i && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (wrap_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Display timing generator. Horizontal and vertical counters run freely; the
// decoded syncs, video qualifier and coordinates are registered together so
// every output describes the same pixel, one clock behind the counters.
//   clock        : pixel clock (65 MHz for 1024x768 @ 60 Hz)
//   reset        : asynchronous active-high reset
//   horiz_sync   : horizontal sync, active level H_SYNC_POL
//   vert_sync    : vertical sync, active level V_SYNC_POL; toggles only at
//                  the start of a line
//   video_on     : pixel is inside the visible region
//   pixel_row    : current line (keeps counting through blanking)
//   pixel_column : current pixel in the line (keeps counting through blanking)
//   line_start   : one-clock pulse at pixel_column == 0
//   frame_start  : one-clock pulse at pixel (0,0)
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VIS      = DEF_H_VIS,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_VIS      = DEF_V_VIS,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    output logic               horiz_sync,
    output logic               vert_sync,
    output logic               video_on,
    output logic [COORD_W-1:0] pixel_row,
    output logic [COORD_W-1:0] pixel_column,
    output logic               line_start,
    output logic               frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    // Totals must fit the coordinate width or the counters would alias.
    if ((H_TOT > COORD_MAX) || (V_TOT > COORD_MAX)) begin : g_total_range_check
        $error("vga_timing_gen: H_TOT or V_TOT does not fit in COORD_W bits");
    end

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] H_VIS_END  = COORD_W'(H_VIS);
    localparam logic [COORD_W-1:0] V_VIS_END  = COORD_W'(V_VIS);
    localparam logic [COORD_W-1:0] HS_FIRST   = COORD_W'(H_VIS + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST    = COORD_W'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST   = COORD_W'(V_VIS + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST    = COORD_W'(V_VIS + V_FP + V_SYNC - 1);

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_wrap;
    logic               v_wrap_unused;  // frame wrap is implied by (0,0) decode

    wrap_counter #(
        .WIDTH (COORD_W),
        .LAST  (H_LAST)
    ) u_h_cnt (
        .clock   (clock),
        .reset   (reset),
        .en_i    (1'b1),
        .count_o (h_cnt),
        .wrap_o  (h_wrap)
    );

    // Vertical counter advances only on the last pixel of each line, so it
    // wraps on the same edge as the horizontal counter at the frame end.
    wrap_counter #(
        .WIDTH (COORD_W),
        .LAST  (V_LAST)
    ) u_v_cnt (
        .clock   (clock),
        .reset   (reset),
        .en_i    (h_wrap),
        .count_o (v_cnt),
        .wrap_o  (v_wrap_unused)
    );

    logic               horiz_sync_q, horiz_sync_d;
    logic               vert_sync_q,  vert_sync_d;
    logic               video_on_q,   video_on_d;
    logic [COORD_W-1:0] pixel_row_q,  pixel_row_d;
    logic [COORD_W-1:0] pixel_col_q,  pixel_col_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;

    always_comb begin
        pixel_col_d   = h_cnt;
        pixel_row_d   = v_cnt;
        horiz_sync_d  = in_window(h_cnt, HS_FIRST, HS_LAST) ? H_SYNC_POL : ~H_SYNC_POL;
        // Depends on v_cnt only, so it can change just when v_cnt does,
        // i.e. at the start of a line.
        vert_sync_d   = in_window(v_cnt, VS_FIRST, VS_LAST) ? V_SYNC_POL : ~V_SYNC_POL;
        video_on_d    = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
        line_start_d  = (h_cnt == '0);
        frame_start_d = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pixel_col_q   <= '0;
            pixel_row_q   <= '0;
            horiz_sync_q  <= ~H_SYNC_POL;
            vert_sync_q   <= ~V_SYNC_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pixel_col_q   <= pixel_col_d;
            pixel_row_q   <= pixel_row_d;
            horiz_sync_q  <= horiz_sync_d;
            vert_sync_q   <= vert_sync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_column = pixel_col_q;
    assign pixel_row    = pixel_row_q;
    assign horiz_sync   = horiz_sync_q;
    assign vert_sync    = vert_sync_q;
    assign video_on     = video_on_q;
    assign line_start   = line_start_q;
    assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Two instances share clock and reset:
//   u_full  : default 1024x768 timing, used for reset, one full line and a
//             mid-line asynchronous reset
//   u_small : 16x6 visible, H_TOT 25, V_TOT 10 (250-clock frame), active-high
//             horiz_sync, used for whole-frame vertical behaviour, wrap and
//             frame-period measurement
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic        f_hs, f_vs, f_vid, f_ls, f_fs;
    logic [11:0] f_row, f_col;
    logic        s_hs, s_vs, s_vid, s_ls, s_fs;
    logic [11:0] s_row, s_col;

    vga_timing_gen u_full (
        .clock        (clk),
        .reset        (rst),
        .horiz_sync   (f_hs),
        .vert_sync    (f_vs),
        .video_on     (f_vid),
        .pixel_row    (f_row),
        .pixel_column (f_col),
        .line_start   (f_ls),
        .frame_start  (f_fs)
    );

    vga_timing_gen #(
        .H_VIS (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_VIS (6),  .V_FP (1), .V_SYNC (2), .V_BP (1),
        .H_SYNC_POL (1'b1), .V_SYNC_POL (1'b0)
    ) u_small (
        .clock        (clk),
        .reset        (rst),
        .horiz_sync   (s_hs),
        .vert_sync    (s_vs),
        .video_on     (s_vid),
        .pixel_row    (s_row),
        .pixel_column (s_col),
        .line_start   (s_ls),
        .frame_start  (s_fs)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling happens on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n_vis, hs_n, hs_first, hs_last, ls_n, fs_n, col_bad, vis_last;
        int max_row, max_col, vs_n, vs_edges, vs_edge_bad, vs_first_row, vs_last_row;
        int vid_bad, last_row, last_col, n;
        logic prev_vs;

        // ---- Reset held 5 clocks ----
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_full_col",  32'(f_col), 0);
        check("rst_full_row",  32'(f_row), 0);
        check("rst_full_vid",  32'(f_vid), 0);
        check("rst_full_ls",   32'(f_ls),  0);
        check("rst_full_fs",   32'(f_fs),  0);
        check("rst_full_hs",   32'(f_hs),  1);
        check("rst_full_vs",   32'(f_vs),  1);
        check("rst_small_hs",  32'(s_hs),  0);
        check("rst_small_vs",  32'(s_vs),  1);
        $display("step reset_hold done");

        // ---- First edge after release ----
        rst = 1'b0;
        tick();
        check("first_col", 32'(f_col), 0);
        check("first_row", 32'(f_row), 0);
        check("first_vid", 32'(f_vid), 1);
        check("first_ls",  32'(f_ls),  1);
        check("first_fs",  32'(f_fs),  1);
        check("first_hs",  32'(f_hs),  1);
        check("first_vs",  32'(f_vs),  1);
        check("first_small_fs", 32'(s_fs), 1);
        check("first_small_hs", 32'(s_hs), 0);
        $display("step reset_release done");

        // ---- One full 1344-pixel line on the default timing ----
        n_vis = 0; hs_n = 0; hs_first = -1; hs_last = -1; ls_n = 0; col_bad = 0; vis_last = -1;
        for (int c = 0; c < 1344; c++) begin
            if (int'(f_col) != c || f_row != 12'd0) col_bad++;
            if (f_vid) begin n_vis++; vis_last = c; end
            if (!f_hs) begin
                hs_n++;
                if (hs_first < 0) hs_first = c;
                hs_last = c;
            end
            if (f_ls) ls_n++;
            if (c != 1343) tick();
        end
        check("line_col_seq",  32'(col_bad),  0);
        check("line_vid_cnt",  32'(n_vis),    1024);
        check("line_vid_last", 32'(vis_last), 1023);
        check("line_hs_cnt",   32'(hs_n),     136);
        check("line_hs_first", 32'(hs_first), 1048);
        check("line_hs_last",  32'(hs_last),  1183);
        check("line_ls_cnt",   32'(ls_n),     1);
        tick();
        check("line2_col", 32'(f_col), 0);
        check("line2_row", 32'(f_row), 1);
        check("line2_ls",  32'(f_ls),  1);
        check("line2_fs",  32'(f_fs),  0);
        $display("step horizontal_line done");

        // ---- Asynchronous reset in the middle of line 1 ----
        repeat (500) tick();
        check("mid_full_col", 32'(f_col), 500);
        #2 rst = 1'b1;
        #1;
        check("async_full_col", 32'(f_col), 0);
        check("async_full_row", 32'(f_row), 0);
        check("async_full_vid", 32'(f_vid), 0);
        check("async_full_hs",  32'(f_hs),  1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("restart_full_fs",  32'(f_fs),  1);
        check("restart_full_col", 32'(f_col), 0);
        check("restart_small_fs", 32'(s_fs),  1);
        $display("step full_midline_reset done");

        // ---- One whole frame on the small timing ----
        max_row = 0; max_col = 0; vs_n = 0; vs_edges = 0; vs_edge_bad = 0;
        vs_first_row = -1; vs_last_row = -1; vid_bad = 0; n_vis = 0; hs_n = 0;
        fs_n = 0; ls_n = 0; last_row = -1; last_col = -1;
        prev_vs = s_vs;
        for (int i = 0; i < 250; i++) begin
            if (int'(s_row) > max_row) max_row = int'(s_row);
            if (int'(s_col) > max_col) max_col = int'(s_col);
            if (s_vid) n_vis++;
            if (s_vid && s_row >= 12'd6) vid_bad++;
            if (s_hs) hs_n++;
            if (!s_vs) begin
                vs_n++;
                if (vs_first_row < 0) vs_first_row = int'(s_row);
                vs_last_row = int'(s_row);
            end
            if (s_vs != prev_vs) begin
                vs_edges++;
                if (s_col != 12'd0) vs_edge_bad++;
            end
            if (s_fs) fs_n++;
            if (s_ls) ls_n++;
            prev_vs  = s_vs;
            last_row = int'(s_row);
            last_col = int'(s_col);
            tick();
        end
        check("frame_max_row",   32'(max_row),      9);
        check("frame_max_col",   32'(max_col),      24);
        check("frame_vid_cnt",   32'(n_vis),        96);
        check("frame_vid_blank", 32'(vid_bad),      0);
        check("frame_hs_cnt",    32'(hs_n),         40);
        check("frame_vs_cnt",    32'(vs_n),         50);
        check("frame_vs_first",  32'(vs_first_row), 7);
        check("frame_vs_last",   32'(vs_last_row),  8);
        check("frame_vs_edges",  32'(vs_edges),     2);
        check("frame_vs_align",  32'(vs_edge_bad),  0);
        check("frame_fs_cnt",    32'(fs_n),         1);
        check("frame_ls_cnt",    32'(ls_n),         10);
        check("wrap_prev_row",   32'(last_row),     9);
        check("wrap_prev_col",   32'(last_col),     24);
        check("wrap_row",        32'(s_row),        0);
        check("wrap_col",        32'(s_col),        0);
        check("wrap_fs",         32'(s_fs),         1);
        $display("step small_frame done");

        // ---- Mid-frame reset on the small timing, then frame period ----
        repeat (113) tick();
        check("mid_small_row", 32'(s_row), 4);
        check("mid_small_col", 32'(s_col), 13);
        #2 rst = 1'b1;
        #1;
        check("async_small_row", 32'(s_row), 0);
        check("async_small_col", 32'(s_col), 0);
        check("async_small_hs",  32'(s_hs),  0);
        check("async_small_vs",  32'(s_vs),  1);
        check("async_small_ls",  32'(s_ls),  0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_fs && n < 20);
        check("restart_small_lat", 32'(n), 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_fs && n < 1000);
        check("small_frame_period", 32'(n), 250);
        $display("step small_midframe_reset done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
